// File: rtl/risc16_prog_loader_if.sv
// rtl/risc16_prog_loader_if.sv - host-to-loader instruction word stream
interface risc16_prog_loader_if #(
    parameter int WORD_LENGTH = 16
);
    logic                   s_valid;
    logic [WORD_LENGTH-1:0] s_data;
    logic                   s_last;
    logic                   s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/risc16_prog_loader.sv
// rtl/risc16_prog_loader.sv - streams a host program into a RiSC16 system
// and sequences its reset and program-enable around the load.
module risc16_prog_loader #(
    parameter int WORD_LENGTH  = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int PURGE_CYCLES = 2,
    parameter int RESET_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    risc16_prog_loader_if.slave    s,
    output logic                   pen,
    output logic                   prog_we,
    output logic [WORD_LENGTH-1:0] instr,
    output logic                   sys_rst,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PURGE = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [15:0]         PURGE_LAST  = 16'(PURGE_CYCLES - 1);
    localparam logic [15:0]         RESET_LAST  = 16'(RESET_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [15:0]              timer_q, timer_d;
    logic [ADDR_WIDTH:0]      count_q, count_d;
    logic [WORD_LENGTH-1:0]   instr_q, instr_d;
    logic                     prog_we_q, prog_we_d;
    logic                     transfer;
    logic                     accept;
    logic                     restart;

    // A handshake at full count is still consumed but never written to memory.
    assign transfer = (state_q == LOAD) && s.s_valid;
    assign accept   = transfer && (count_q != MAX_COUNT);
    assign restart  = start && ((state_q == IDLE) || (state_q == RUN) || (state_q == ERROR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            instr_q   <= '0;
            prog_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            prog_we_q <= prog_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PURGE;
            PURGE:   if (timer_q == PURGE_LAST) state_d = LOAD;
            LOAD: begin
                if (transfer && !accept) state_d = ERROR;
                else if (accept && s.s_last) state_d = FLUSH;
            end
            FLUSH:   if (timer_q == RESET_LAST) state_d = RUN;
            RUN:     if (start) state_d = PURGE;
            ERROR:   if (start) state_d = PURGE;
            default: state_d = IDLE;
        endcase

        // The phase timer restarts on every state change.
        timer_d   = (state_d != state_q) ? '0 : timer_q + 16'd1;
        prog_we_d = accept;
        instr_d   = accept ? s.s_data : instr_q;
        if (restart)     count_d = '0;
        else if (accept) count_d = count_q + 1'b1;
        else             count_d = count_q;
    end

    always_comb begin
        s.s_ready = (state_q == LOAD);
        pen       = (state_q == PURGE) || (state_q == LOAD);
        sys_rst   = (state_q == IDLE) || (state_q == PURGE) ||
                    (state_q == FLUSH) || (state_q == ERROR);
        busy      = (state_q == PURGE) || (state_q == LOAD) || (state_q == FLUSH);
        done      = (state_q == RUN);
        error     = (state_q == ERROR);
        prog_we   = prog_we_q;
        instr     = instr_q;
        count     = count_q;
    end
endmodule

// File: tb/tb_risc16_prog_loader.sv
// tb/tb_risc16_prog_loader.sv - scoreboard bench for risc16_prog_loader
module tb_risc16_prog_loader;
    localparam int WL   = 16;
    localparam int AW   = 2;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pen, prog_we, sys_rst, busy, done, error;
    logic [WL-1:0] instr;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    risc16_prog_loader_if #(.WORD_LENGTH(WL)) bus ();

    risc16_prog_loader #(
        .WORD_LENGTH(WL), .ADDR_WIDTH(AW), .PURGE_CYCLES(2), .RESET_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s(bus),
        .pen(pen), .prog_we(prog_we), .instr(instr), .sys_rst(sys_rst),
        .count(count), .busy(busy), .done(done), .error(error)
    );

    typedef struct packed {
        logic [WL-1:0] data;
        logic [31:0]   cnt;
    } exp_t;

    exp_t          expq[$];
    int            checks   = 0;
    int            failures = 0;
    int            model_cnt;
    logic [WL-1:0] words[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status vector order: {sys_rst, pen, s_ready, busy, done, error}
    task automatic check_status(input string name, input logic [5:0] exp);
        check(name, {26'd0, sys_rst, pen, bus.s_ready, busy, done, error}, {26'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (prog_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_prog_we actual=1 expected=0 instr=%h at %0t", instr, $time);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("prog_we_instr", {16'd0, instr}, {16'd0, e.data});
                check("prog_we_count", {29'd0, count}, e.cnt);
            end
        end
    end

    // gap < 0 selects random gaps; inject drives start alongside some transfers.
    task automatic run_session(input int nwords, input bit use_last, input int gap, input bit inject);
        bit accepted;
        bit last;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_cnt = 0;
        check_status("purge_c1", 6'b110100);
        check("purge_count", {29'd0, count}, 32'd0);
        tick;
        check_status("purge_c2", 6'b110100);
        tick;
        check_status("load_entry", 6'b011100);
        for (int k = 0; k < nwords; k++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : ((k == 0) ? 0 : gap);
            for (int j = 0; j < g; j++) begin
                tick;
                check_status("load_gap", 6'b011100);
            end
            last = use_last && (k == nwords - 1);
            bus.s_valid = 1'b1;
            bus.s_data  = words[k];
            bus.s_last  = last;
            start       = inject && ($urandom_range(0, 3) == 0);
            accepted    = (model_cnt < MAXW);
            if (accepted) begin
                model_cnt++;
                expq.push_back('{data: words[k], cnt: 32'(model_cnt)});
            end
            tick;
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            start       = 1'b0;
            @(negedge clk);
            #1;
            check("pending_writes", 32'(expq.size()), 32'd0);
            check("word_count", {29'd0, count}, 32'(model_cnt));
            if (!accepted) begin
                check_status("error_state", 6'b100001);
                break;
            end else if (last) begin
                check_status("flush_c1", 6'b100100);
                tick;
                check_status("flush_c2", 6'b100100);
                tick;
                check_status("run_state", 6'b000010);
                check("run_count", {29'd0, count}, 32'(model_cnt));
                break;
            end else begin
                check_status("load_after_word", 6'b011100);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) tick;
        check_status("reset_status", 6'b100000);
        check("reset_outs", {19'd0, prog_we, instr, count}, 32'd0);
        rst = 1'b1;
        repeat (3) tick;
        check_status("idle_after_release", 6'b100000);

        words[0] = 16'h6A00; words[1] = 16'h6D00; words[2] = 16'h0903;
        run_session(3, 1'b1, 0, 1'b0);
        run_session(3, 1'b1, 3, 1'b0);

        for (int k = 0; k < 5; k++) words[k] = 16'(16'h1000 + k);
        run_session(5, 1'b0, 0, 1'b0);
        run_session(4, 1'b1, 1, 1'b0);

        words[0] = 16'h0000;
        run_session(1, 1'b1, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            int len;
            bit lst;
            lst = ($urandom_range(0, 3) != 0);
            len = lst ? int'($urandom_range(1, MAXW)) : MAXW + 1;
            for (int k = 0; k < len; k++) words[k] = 16'($urandom);
            run_session(len, lst, -1, 1'b1);
        end

        // Abort mid-load: two words written, then reset.
        words[0] = 16'hA5A5; words[1] = 16'h5A5A;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        for (int k = 0; k < 2; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = words[k];
            expq.push_back('{data: words[k], cnt: 32'(k + 1)});
            tick;
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("abort_pending", 32'(expq.size()), 32'd0);
        rst = 1'b0;
        #1;
        check_status("abort_status", 6'b100000);
        check("abort_outs", {19'd0, prog_we, instr, count}, 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hDEAD;
        repeat (2) tick;
        rst = 1'b1;
        repeat (3) tick;
        bus.s_valid = 1'b0;
        check_status("abort_idle", 6'b100000);
        check("abort_idle_outs", {19'd0, prog_we, instr, count}, 32'd0);

        repeat (3) tick;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/risc16_prog_loader.md
RISC16_PROG_LOADER -- requirements
Module: risc16_prog_loader

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, log2 of maximum program length (256 words).
REQ-003 SHALL have parameter PURGE_CYCLES, default 2, cycles of system reset before loading.
REQ-004 SHALL have parameter RESET_CYCLES, default 2, cycles of system reset between load and run.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a programming session.
REQ-008 SHALL have port s_valid  input  1  host word valid.
REQ-009 SHALL have port s_data  input  WORD_LENGTH  host instruction word.
REQ-010 SHALL have port s_last  input  1  marks final word of program, qualified by s_valid.
REQ-011 SHALL have port s_ready  output  1  loader accepts word this cycle.
REQ-012 SHALL have port pen  output  1  program-enable to the RiSC16 system.
REQ-013 SHALL have port prog_we  output  1  one-cycle instruction-write strobe to the system.
REQ-014 SHALL have port instr  output  WORD_LENGTH  instruction word to the system.
REQ-015 SHALL have port sys_rst  output  1  active-high reset to the RiSC16 system.
REQ-016 SHALL have port count  output  ADDR_WIDTH+1  number of words written this session.
REQ-017 SHALL have ports busy, done, error  output  1 each  session status flags.

Function
REQ-018 SHALL implement states IDLE, PURGE, LOAD, FLUSH, RUN, ERROR.
REQ-019 IDLE SHALL hold sys_rst=1, pen=0, s_ready=0; start moves to PURGE, clears count, done, error.
REQ-020 PURGE SHALL hold sys_rst=1, pen=1 for exactly PURGE_CYCLES cycles, then enter LOAD.
REQ-021 LOAD SHALL drive sys_rst=0, pen=1, s_ready=1; transfer occurs when s_valid and s_ready are both high on a rising edge.
REQ-022 Each transfer SHALL register s_data onto instr and pulse prog_we for exactly one cycle, the cycle after the transfer.
REQ-023 Each transfer SHALL increment count by 1; instr SHALL hold its last value when prog_we=0.
REQ-024 Cycles in LOAD without transfer SHALL leave prog_we=0 and pen=1; gaps of any length are legal.
REQ-025 A transfer with s_last=1 SHALL move to FLUSH; s_ready SHALL be 0 from the next cycle.
REQ-026 A transfer that would make count exceed 2^ADDR_WIDTH without s_last SHALL be refused (no prog_we), and SHALL move to ERROR with error=1.
REQ-027 A transfer with s_last=1 at count=2^ADDR_WIDTH-1 SHALL complete normally (count=2^ADDR_WIDTH).
REQ-028 FLUSH SHALL drive pen=0, sys_rst=1 for exactly RESET_CYCLES cycles, then enter RUN.
REQ-029 RUN SHALL drive sys_rst=0, pen=0, done=1, busy=0 until the next start.
REQ-030 ERROR SHALL drive sys_rst=1, pen=0, s_ready=0, error=1 until the next start.
REQ-031 busy SHALL be 1 in PURGE, LOAD, FLUSH and 0 elsewhere.
REQ-032 start in PURGE, LOAD or FLUSH SHALL be ignored; start in RUN or ERROR SHALL restart at PURGE.
REQ-033 start and a transfer in the same cycle SHALL not occur outside LOAD; in LOAD start is ignored and the transfer proceeds.

Reset
REQ-034 rst low SHALL immediately force IDLE, sys_rst=1, pen=0, prog_we=0, s_ready=0, instr=0, count=0, busy=0, done=0, error=0.
REQ-035 rst asserted mid-LOAD SHALL abort the session with no further prog_we; words already written are not rolled back.
REQ-036 Outputs SHALL leave reset values only after rst rises and a start is seen.

Verification
REQ-037 rst low, then high, start -> 2 cycles sys_rst=1,pen=1; then s_ready=1, sys_rst=0.
REQ-038 Stream 0x6A00, 0x6D00, 0x0903 (last on third), back-to-back -> three prog_we pulses with matching instr, count=3, then pen=0, sys_rst=1 for 2 cycles, then done=1, sys_rst=0.
REQ-039 Same stream with s_valid low for 3 cycles between words -> identical prog_we/instr sequence, pen=1 throughout gaps.
REQ-040 ADDR_WIDTH=2, stream 5 words, no last -> 4 prog_we pulses, 5th refused, error=1, sys_rst=1, count=4.
REQ-041 rst pulsed low after second word accepted -> outputs at reset values same cycle, no third prog_we.
REQ-042 In RUN, start -> done=0, PURGE entered, count=0, new session loads 0x0000 with last -> count=1, done=1.
